frame_buffer_reader: RTL and testbench
======================================

// Module: frame_buffer_reader
// PURPOSE
// - Read side of the median-filter frame buffer: after a start pulse, reads IMG_W*IMG_H pixels in raster order
//   from a synchronous 1-cycle-latency RAM read port and emits them as a valid/ready pixel stream.
// - Row/column counters generate the addresses and the start/end-of-line and end-of-frame markers.
// - Sits between the frame buffer written by the capture path and the median window/line-buffer stage.
// PARAMETERS
// - DATA_W  8   pixel width in bits
// - ADDR_W  16  RAM address width; IMG_W*IMG_H must be <= 2**ADDR_W
// - IMG_W   64  pixels per line, >= 2
// - IMG_H   64  lines per frame, >= 1
// PORTS
// - clk          in   1       clock, all logic on rising edge
// - rst_n        in   1       reset, asynchronous, active-low
// - start        in   1       begin one frame read; sampled only in IDLE
// - busy         out  1       high from the cycle after start is accepted until done
// - done         out  1       one-cycle pulse after the last pixel handshake
// - mem_rd_en    out  1       RAM read strobe
// - mem_addr     out  ADDR_W  RAM read address, valid when mem_rd_en=1
// - mem_rd_data  in   DATA_W  RAM data, valid the cycle after mem_rd_en
// - out_valid    out  1       out_data and the markers are valid
// - out_ready    in   1       downstream accepts; handshake = out_valid & out_ready
// - out_data     out  DATA_W  pixel
// - out_sol      out  1       pixel is column 0
// - out_eol      out  1       pixel is column IMG_W-1
// - out_eof      out  1       pixel is last of frame (row IMG_H-1, col IMG_W-1)
// BEHAVIOUR
// - Reset: state IDLE; busy, done, mem_rd_en, out_valid, out_sol, out_eol, out_eof = 0; mem_addr, out_data = 0;
//   row/col/address counters, in-flight flag and output buffer cleared. Reset mid-frame aborts with no done pulse.
// - FSM: IDLE --start--> READ --last read issued--> DRAIN --last pixel handshake--> IDLE (done=1 for that cycle).
//   start is ignored in READ and DRAIN; start in the same cycle as done is ignored.
// - Read issue (READ only): mem_rd_en=1 when occ + inflight - pop < 2, where occ = output buffer entries (0..2),
//   inflight = read issued in the previous cycle, pop = output handshake this cycle. Sustains 1 pixel/cycle
//   with out_ready held high; with out_ready low, at most 2 pixels are buffered and no RAM data is ever lost.
// - Addressing: mem_addr = row*IMG_W + col, kept as a linear counter (no multiplier); col wraps IMG_W-1 -> 0 and
//   row increments; after the read of (IMG_H-1, IMG_W-1) the counters return to 0 and the FSM enters DRAIN.
// - Markers are computed from row/col at issue time and carried with the in-flight read into the 2-entry
//   output buffer, so they always align with their pixel.
// - Latency: start sampled at edge k -> busy=1 and mem_rd_en=1 (addr 0) in cycle k+1 -> mem_rd_data in k+2,
//   captured into the buffer -> out_valid=1 with pixel 0 in cycle k+3.
// - out_valid/out_data/markers hold stable while out_valid=1 and out_ready=0 (no retraction, no change).
// - Output buffer: FIFO order, 2 entries; simultaneous push and pop is legal at any occupancy 0..2 that the
//   issue rule permits; overflow is impossible by construction (assertion in bench).
// - done: registered, asserted the cycle after the handshake of the out_eof pixel; busy falls in the same cycle.
// - Frame with IMG_H=1: out_eol and out_eof both set on the final pixel; out_sol and out_eol never both set.
// TESTING
// - IMG_W=4, IMG_H=3, RAM[a]=a, out_ready=1, start pulse -> mem_addr 0..11 on 12 consecutive cycles; out_data
//   0..11 on 12 consecutive cycles starting 3 cycles after start; done pulse the cycle after data 11.
// - Same frame, out_ready toggling 1,0,0,1 pattern -> every pixel delivered exactly once in order; mem_rd_en
//   stalls with buffer full; data stable during stalls; no more than 2 pixels outstanding.
// - Markers: out_sol on 0,4,8; out_eol on 3,7,11; out_eof only on 11; markers checked under backpressure too.
// - start re-pulsed at cycles 5 and in the done cycle -> ignored: exactly 12 pixels, one done pulse, then
//   a new start in IDLE reads addresses 0..11 again.
// - rst_n low for 1 cycle mid-frame (after pixel 5) -> all outputs 0 immediately, no done; next start
//   restarts from address 0 with out_sol set on the first pixel.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// Read side of the median-filter frame buffer: streams IMG_W*IMG_H pixels in raster order
// from a 1-cycle-latency RAM into a valid/ready pixel stream with line/frame markers.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing RAM reads while the output buffer has room
// DRAIN | all reads issued, waiting for the last pixel handshake
module frame_buffer_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sol,
   output logic              out_eol,
   output logic              out_eof
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int ENT_W = DATA_W + 3;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] addr;
   logic              inflight;
   logic [2:0]        inflight_mk;
   logic [ENT_W-1:0]  buf0, buf1;
   logic [1:0]        occ;
   logic [1:0]        wr_idx;
   logic              pop, push, room, last_issue, last_pop, done_q;

   // buffer entry layout: {eof, eol, sol, data}
   assign pop        = (occ != 2'd0) && out_ready;
   assign push       = inflight;
   assign wr_idx     = occ - {1'b0, pop};
   assign room       = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
   assign last_issue = mem_rd_en && (col == COL_LAST) && (row == ROW_LAST);
   assign last_pop   = pop && buf0[DATA_W+2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !done_q) state_nxt = READ;
         READ:    if (last_issue)       state_nxt = DRAIN;
         DRAIN:   if (last_pop)         state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      mem_rd_en = (state == READ) && room;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col         <= '0;
         row         <= '0;
         addr        <= '0;
         inflight    <= 1'b0;
         inflight_mk <= 3'b000;
         buf0        <= '0;
         buf1        <= '0;
         occ         <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         done_q   <= (state == DRAIN) && last_pop;
         inflight <= mem_rd_en;
         if (mem_rd_en) begin
            inflight_mk <= {(col == COL_LAST) && (row == ROW_LAST), col == COL_LAST, col == '0};
            addr        <= last_issue ? '0 : addr + 1'b1;
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         // shift first, then a push into the same slot overrides the shifted value
         if (pop) buf0 <= buf1;
         if (push) begin
            if (wr_idx == 2'd0) buf0 <= {inflight_mk, mem_rd_data};
            else                buf1 <= {inflight_mk, mem_rd_data};
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign done      = done_q;
   assign mem_addr  = addr;
   assign out_valid = (occ != 2'd0);
   assign out_data  = buf0[DATA_W-1:0];
   assign out_sol   = out_valid && buf0[DATA_W];
   assign out_eol   = out_valid && buf0[DATA_W+1];
   assign out_eof   = out_valid && buf0[DATA_W+2];

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader on a 4x3 frame: a raster-order pixel model compared every
// cycle, plus directed latency/marker/restart/reset scenarios and randomized backpressure.
module tb_frame_buffer_reader;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 16;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int N      = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic              out_sol, out_eol, out_eof;

   frame_buffer_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] ram [N];
   always @(posedge clk)
      if (mem_rd_en) mem_rd_data <= (mem_addr < ADDR_W'(N)) ? ram[int'(mem_addr)] : 8'hEE;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ready generator: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
   int       mode = 0;
   int       pi = 0;
   logic [3:0] pat = 4'b1001;
   always @(posedge clk) begin
      #1;
      case (mode)
         1:       begin out_ready = pat[3 - (pi % 4)]; pi++; end
         2:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1'b1;
      endcase
   end

   // behavioural model: a frame is the list ram[0..N-1] in order, tagged by index arithmetic
   bit busy_m = 0, done_m = 0;
   int rd_idx = 0, px_idx = 0, frames = 0, done_cnt = 0;
   int first_rd_cyc, last_rd_cyc, first_val_cyc, last_val_cyc, done_cyc;
   int rd_gap = 0, stall_cnt = 0;
   bit prev_stall = 0;
   longint prev_pix;
   logic [N-1:0] sol_mask, eol_mask, eof_mask;

   always @(negedge clk) begin
      bit     hs, hs_eof, start_acc;
      longint pix, exp_pix;
      int     outst;
      if (!rst_n) begin
         chk(!busy && !done && !mem_rd_en && !out_valid && !out_sol && !out_eol && !out_eof &&
             mem_addr == 0 && out_data == 0, "reset_outputs",
             {busy, done, mem_rd_en, out_valid, out_sol, out_eol, out_eof}, 0);
         busy_m = 0; done_m = 0; rd_idx = 0; px_idx = 0; prev_stall = 0;
      end else begin
         hs_eof = 0;
         chk(busy == busy_m, "busy", busy, busy_m);
         chk(done == done_m, "done", done, done_m);
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (busy_m && rd_idx < N && !mem_rd_en) rd_gap++;
         if (mem_rd_en) begin
            chk(busy_m && rd_idx < N && mem_addr == ADDR_W'(rd_idx), "rd_addr", mem_addr, rd_idx);
            if (rd_idx == 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            rd_idx++;
         end
         pix = {out_eof, out_eol, out_sol, out_data};
         if (prev_stall) begin
            stall_cnt++;
            chk(out_valid && pix == prev_pix, "stall_hold", pix, prev_pix);
         end
         if (out_valid) begin
            if (px_idx < N)
               exp_pix = {px_idx == N - 1, (px_idx % IMG_W) == IMG_W - 1, (px_idx % IMG_W) == 0,
                          ram[px_idx]};
            else
               exp_pix = -1;
            chk(px_idx < N && pix == exp_pix, "pixel", pix, exp_pix);
            if (px_idx == 0) first_val_cyc = cyc;
         end
         hs = out_valid && out_ready;
         outst = rd_idx - px_idx - int'(hs);
         chk(outst >= 0 && outst <= 2, "outstanding", outst, 2);
         if (hs && px_idx < N) begin
            sol_mask[px_idx] = out_sol;
            eol_mask[px_idx] = out_eol;
            eof_mask[px_idx] = out_eof;
            if (px_idx == N - 1) hs_eof = 1;
            last_val_cyc = cyc;
            px_idx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_pix = pix;
         start_acc = !busy_m && start && !done_m;
         done_m = hs_eof;
         if (hs_eof) busy_m = 0;
         if (start_acc) begin
            busy_m = 1; rd_idx = 0; px_idx = 0; frames++;
            sol_mask = '0; eol_mask = '0; eof_mask = '0;
         end
      end
   end

   int k;

   task automatic start_pulse();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = cyc;
   endtask

   task automatic wait_done(input int maxc);
      int d0 = done_cnt;
      bit seen = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) begin seen = 1; break; end
      end
      chk(seen, "done_timeout", seen, 1);
   endtask

   task automatic check_markers();
      chk(sol_mask == 12'h111, "sol_mask", sol_mask, 12'h111);
      chk(eol_mask == 12'h888, "eol_mask", eol_mask, 12'h888);
      chk(eof_mask == 12'h800, "eof_mask", eof_mask, 12'h800);
      chk(px_idx == N, "pixel_count", px_idx, N);
   endtask

   initial begin
      int d0, f0;
      bit got;
      for (int i = 0; i < N; i++) ram[i] = DATA_W'(i);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk(busy == 0 && out_valid == 0 && mem_rd_en == 0, "idle_after_reset",
          {busy, out_valid, mem_rd_en}, 0);

      // full-rate frame with literal timing
      mode = 0;
      d0 = done_cnt;
      start_pulse();
      wait_done(100);
      chk(first_rd_cyc == k, "first_rd", first_rd_cyc, k);
      chk(last_rd_cyc == k + 11, "last_rd", last_rd_cyc, k + 11);
      chk(first_val_cyc == k + 2, "first_valid", first_val_cyc, k + 2);
      chk(last_val_cyc == k + 13, "last_valid", last_val_cyc, k + 13);
      chk(done_cyc == k + 14, "done_cycle", done_cyc, k + 14);
      chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
      check_markers();

      // 1,0,0,1 backpressure
      repeat (3) @(posedge clk);
      mode = 1; pi = 0; rd_gap = 0; stall_cnt = 0;
      start_pulse();
      wait_done(200);
      check_markers();
      chk(rd_gap > 0, "read_stalled", rd_gap, 1);
      chk(stall_cnt > 0, "output_stalled", stall_cnt, 1);

      // start re-pulsed mid-frame and in the done cycle
      mode = 0;
      repeat (3) @(posedge clk);
      d0 = done_cnt; f0 = frames;
      start_pulse();
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done) begin got = 1; start = 1'b1; break; end
      end
      chk(got, "done_seen", got, 1);
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk(busy == 0, "start_in_done_ignored", busy, 0);
      chk(done_cnt - d0 == 1, "single_done", done_cnt - d0, 1);
      chk(frames - f0 == 1, "single_frame", frames - f0, 1);
      check_markers();
      start_pulse();
      wait_done(100);
      chk(first_rd_cyc == k, "restart_first_rd", first_rd_cyc, k);
      check_markers();

      // reset mid-frame after pixel 5
      repeat (3) @(posedge clk);
      d0 = done_cnt;
      start_pulse();
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (px_idx >= 6) begin got = 1; break; end
      end
      chk(got, "reached_pixel6", got, 1);
      rst_n = 1'b0;
      #1;
      chk(!out_valid && !mem_rd_en && !busy && !out_sol, "reset_immediate",
          {out_valid, mem_rd_en, busy, out_sol}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk(done_cnt == d0, "no_done_after_abort", done_cnt - d0, 0);
      start_pulse();
      wait_done(100);
      chk(first_rd_cyc == k, "post_reset_first_rd", first_rd_cyc, k);
      check_markers();

      // randomized frames: random RAM, random ready, stray start pulses
      mode = 2;
      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(1, 4)) @(posedge clk);
         for (int i = 0; i < N; i++) ram[i] = DATA_W'($urandom);
         start_pulse();
         got = 0;
         for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) begin start = 1'b0; got = 1; break; end
            start = ($urandom_range(0, 7) == 0);
         end
         start = 1'b0;
         chk(got, "rand_done", got, 1);
         @(negedge clk);
         check_markers();
      end

      mode = 0;
      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
